// File: rtl/retospect_lif_neuron.sv
// retospect_lif_neuron: leaky integrate-and-fire neuron cell with N_DEND
// weighted dendrites, programmable threshold, decay strobe select and
// refractory period. All configuration lives on one serial shift chain
// (bs_in -> w[0] .. w[N_DEND-1], thr, sel, ref -> bs_out).
// Optional feature macro: RETOSPECT_INHIB_EN (signed, inhibitory weights).
module retospect_lif_neuron #(
    parameter int N_DEND   = 4,
    parameter int W_BITS   = 4,
    parameter int POT_BITS = 6,
    parameter int CLK_W    = 8,
    parameter int REF_BITS = 3,
    parameter int INIT_POT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reset_nn,
    input  logic                config_en,
    input  logic                bs_in,
    output logic                bs_out,
    input  logic [CLK_W-1:0]    clockbus,
    input  logic [N_DEND-1:0]   dendrite,
    output logic                axon,
    output logic [POT_BITS-1:0] potential,
    output logic                refractory
);
    localparam int SEL_BITS = $clog2(CLK_W);
    localparam int CFG_BITS = N_DEND*W_BITS + POT_BITS + SEL_BITS + REF_BITS;
    localparam int ACC_BITS = POT_BITS + $clog2(N_DEND) + 1;
    localparam int REF_LSB  = 0;
    localparam int SEL_LSB  = REF_LSB + REF_BITS;
    localparam int THR_LSB  = SEL_LSB + SEL_BITS;
    localparam int W_LSB    = THR_LSB + POT_BITS;
    localparam logic [ACC_BITS-1:0] POT_MAX = ACC_BITS'((1 << POT_BITS) - 1);

    // cfg[CFG_BITS-1] is the MSB of w[0] and receives bs_in; cfg[0] is the
    // LSB of the refractory field and drives bs_out.
    logic [CFG_BITS-1:0] cfg;
    logic [POT_BITS-1:0] thr;
    logic [SEL_BITS-1:0] sel;
    logic [REF_BITS-1:0] ref_len;

    logic [POT_BITS-1:0] pot_q, pot_d;
    logic [REF_BITS-1:0] rc_q, rc_d;
    logic                axon_q, axon_d;

    logic                decay;
    logic [POT_BITS-1:0] base;
    logic [POT_BITS-1:0] nxt_sat;
    logic                fire;
`ifdef RETOSPECT_INHIB_EN
    logic signed [ACC_BITS-1:0] sum;
    logic signed [ACC_BITS-1:0] nxt;
`else
    logic [ACC_BITS-1:0] sum;
    logic [ACC_BITS-1:0] nxt;
`endif

    assign thr        = cfg[THR_LSB +: POT_BITS];
    assign sel        = cfg[SEL_LSB +: SEL_BITS];
    assign ref_len    = cfg[REF_LSB +: REF_BITS];
    assign bs_out     = cfg[REF_LSB];
    assign axon       = axon_q;
    assign potential  = pot_q;
    assign refractory = (rc_q != '0);

    // Configuration chain: shifts one bit per enabled cycle unless a network re-init takes priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg <= '0;
        end else if (!reset_nn && config_en) begin
            cfg <= {bs_in, cfg[CFG_BITS-1:1]};
        end
    end

    // Decay strobe: selected clockbus bit, forced low for out-of-range selects
    always_comb begin
        decay = 1'b0;
        if (int'(sel) < CLK_W) begin
            decay = clockbus[sel];
        end
    end

    // Accumulate the weights of every active dendrite
    always_comb begin
        logic [W_BITS-1:0] wv;
        wv  = '0;
        sum = '0;
        for (int i = 0; i < N_DEND; i++) begin
            wv = cfg[W_LSB + (N_DEND-1-i)*W_BITS +: W_BITS];
            if (dendrite[i]) begin
`ifdef RETOSPECT_INHIB_EN
                sum = sum + ACC_BITS'($signed(wv));
`else
                sum = sum + ACC_BITS'(wv);
`endif
            end
        end
    end

    // Leak, integrate, clamp to the potential range and compare with threshold
    always_comb begin
        base = decay ? (pot_q >> 1) : pot_q;
`ifdef RETOSPECT_INHIB_EN
        nxt = $signed(ACC_BITS'(base)) + sum;
        if (nxt < 0) begin
            nxt_sat = '0;
        end else if (nxt > $signed(POT_MAX)) begin
            nxt_sat = '1;
        end else begin
            nxt_sat = nxt[POT_BITS-1:0];
        end
`else
        nxt = ACC_BITS'(base) + sum;
        if (nxt > POT_MAX) begin
            nxt_sat = '1;
        end else begin
            nxt_sat = nxt[POT_BITS-1:0];
        end
`endif
        fire = (nxt_sat >= thr);
    end

    // Next neuron state: re-init, then config hold, then refractory countdown, then integrate/fire
    always_comb begin
        pot_d  = pot_q;
        rc_d   = rc_q;
        axon_d = 1'b0;
        if (reset_nn) begin
            pot_d = POT_BITS'(INIT_POT);
            rc_d  = '0;
        end else if (!config_en) begin
            if (rc_q != '0) begin
                rc_d  = rc_q - REF_BITS'(1);
                pot_d = '0;
            end else if (fire) begin
                axon_d = 1'b1;
                pot_d  = '0;
                rc_d   = ref_len;
            end else begin
                pot_d = nxt_sat;
            end
        end
    end

    // Neuron state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pot_q  <= '0;
            rc_q   <= '0;
            axon_q <= 1'b0;
        end else begin
            pot_q  <= pot_d;
            rc_q   <= rc_d;
            axon_q <= axon_d;
        end
    end

endmodule

// File: tb/tb_retospect_lif_neuron.sv
// tb_retospect_lif_neuron: self-checking bench for retospect_lif_neuron at
// default parameters. Directed vectors plus random traffic compared with a
// behavioural model (config held as a bit queue, neuron rules as integers).
// Define RETOSPECT_INHIB_EN for both files to exercise signed weights.
module tb_retospect_lif_neuron;
    localparam int L        = 28;
    localparam int INIT_POT = 1;
    localparam int POT_MAX  = 63;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reset_nn = 1'b0;
    logic       config_en = 1'b0;
    logic       bs_in = 1'b0;
    logic       bs_out;
    logic [7:0] clockbus = 8'b0000_0010;
    logic [3:0] dendrite = 4'b0000;
    logic       axon;
    logic [5:0] potential;
    logic       refractory;

    int n_checks = 0;
    int n_fails  = 0;

    // behavioural model state
    int m_pot;
    int m_rc;
    bit m_axon;
    bit m_chain[$];

    typedef struct {
        logic [3:0] dend;
        int         exp_pot;
        logic       exp_axon;
        logic       exp_refr;
    } vec_t;

    vec_t tbl[8];

    retospect_lif_neuron dut (
        .clk        (clk),
        .reset      (reset),
        .reset_nn   (reset_nn),
        .config_en  (config_en),
        .bs_in      (bs_in),
        .bs_out     (bs_out),
        .clockbus   (clockbus),
        .dendrite   (dendrite),
        .axon       (axon),
        .potential  (potential),
        .refractory (refractory)
    );

    always #5 clk = ~clk;

    // Config field value from the model chain; index 0 is the bit nearest bs_out
    function automatic int field(int lsb, int width);
        int v;
        v = 0;
        for (int k = 0; k < width; k++) begin
            if (m_chain[lsb + k]) v += (1 << k);
        end
        return v;
    endfunction

    // Weight of dendrite i; w[0] sits nearest bs_in
    function automatic int weight_of(int i);
        int v;
        v = field(24 - 4*i, 4);
`ifdef RETOSPECT_INHIB_EN
        if (v >= 8) v -= 16;
`endif
        return v;
    endfunction

    task automatic model_reset();
        m_pot  = 0;
        m_rc   = 0;
        m_axon = 0;
        m_chain.delete();
        for (int k = 0; k < L; k++) m_chain.push_back(1'b0);
    endtask

    task automatic model_step();
        int sel, base, sum, nxt;
        if (reset_nn) begin
            m_pot  = INIT_POT;
            m_rc   = 0;
            m_axon = 0;
        end else if (config_en) begin
            m_chain.push_back(bs_in);
            void'(m_chain.pop_front());
            m_axon = 0;
        end else if (m_rc > 0) begin
            m_rc   = m_rc - 1;
            m_pot  = 0;
            m_axon = 0;
        end else begin
            sel  = field(3, 3);
            base = (sel < 8 && clockbus[sel]) ? m_pot / 2 : m_pot;
            sum  = 0;
            for (int i = 0; i < 4; i++) begin
                if (dendrite[i]) sum += weight_of(i);
            end
            nxt = base + sum;
            if (nxt < 0) nxt = 0;
            if (nxt > POT_MAX) nxt = POT_MAX;
            if (nxt >= field(6, 6)) begin
                m_axon = 1;
                m_pot  = 0;
                m_rc   = field(0, 3);
            end else begin
                m_axon = 0;
                m_pot  = nxt;
            end
        end
    endtask

    task automatic check_val(string name, logic [31:0] actual, logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_output(string name, int exp_pot, logic exp_axon, logic exp_refr);
        check_val({name, " potential"}, 32'(potential), exp_pot);
        check_val({name, " axon"}, 32'(axon), 32'(exp_axon));
        check_val({name, " refractory"}, 32'(refractory), 32'(exp_refr));
    endtask

    task automatic check_model(string name);
        check_output(name, m_pot, m_axon, m_rc != 0);
        check_val({name, " bs_out"}, 32'(bs_out), 32'(m_chain[0]));
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle past the edge
    task automatic apply_stimulus(logic rn, logic ce, logic bi, logic [3:0] dend);
        reset_nn  = rn;
        config_en = ce;
        bs_in     = bi;
        dendrite  = dend;
        clockbus  = {6'($urandom), 2'b10};
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        reset_nn  = 1'b0;
        config_en = 1'b0;
        model_reset();
        #7;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_config(int w0, int w1, int w2, int w3, int thr, int sel, int refv);
        logic [27:0] v;
        v[27:24] = 4'(w0);
        v[23:20] = 4'(w1);
        v[19:16] = 4'(w2);
        v[15:12] = 4'(w3);
        v[11:6]  = 6'(thr);
        v[5:3]   = 3'(sel);
        v[2:0]   = 3'(refv);
        for (int j = 0; j < L; j++) apply_stimulus(1'b0, 1'b1, v[j], 4'($urandom));
        config_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [27:0] pat_a, pat_b;
        int r;

        // reset state
        do_reset();
        check_output("reset", 0, 1'b0, 1'b0);
        check_val("reset bs_out", 32'(bs_out), 0);

        // integration: w0=3, thr=10, fires every fourth edge
        tbl[0] = '{4'b0001, 3, 1'b0, 1'b0};
        tbl[1] = '{4'b0001, 6, 1'b0, 1'b0};
        tbl[2] = '{4'b0001, 9, 1'b0, 1'b0};
        tbl[3] = '{4'b0001, 0, 1'b1, 1'b0};
        tbl[4] = '{4'b0001, 3, 1'b0, 1'b0};
        tbl[5] = '{4'b0001, 6, 1'b0, 1'b0};
        tbl[6] = '{4'b0001, 9, 1'b0, 1'b0};
        tbl[7] = '{4'b0001, 0, 1'b1, 1'b0};
        load_config(3, 0, 0, 0, 10, 0, 0);
        check_output("integ hold during config", 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, tbl[i].dend);
            check_output($sformatf("integ[%0d]", i), tbl[i].exp_pot, tbl[i].exp_axon, tbl[i].exp_refr);
            check_model($sformatf("integ model[%0d]", i));
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
        check_output("integ pre-chain", 6, 1'b0, 1'b0);

        // chain: A then B; bs_out replays A from shift 29, potential held at 6
        pat_a = 28'($urandom);
        pat_b = 28'($urandom);
        for (int j = 0; j < L; j++) begin
            apply_stimulus(1'b0, 1'b1, pat_a[j], 4'b1111);
            check_model($sformatf("chain A[%0d]", j));
        end
        for (int j = 0; j < L; j++) begin
            check_val($sformatf("chain bs_out[%0d]", j), 32'(bs_out), 32'(pat_a[j]));
            apply_stimulus(1'b0, 1'b1, pat_b[j], 4'b1111);
            check_output($sformatf("chain B hold[%0d]", j), 6, 1'b0, 1'b0);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        check_output("chain reset_nn", 1, 1'b0, 1'b0);
        check_val("chain cfg kept", 32'(bs_out), 32'(pat_b[0]));

        // saturation: all weights 15, thr=63
        do_reset();
        load_config(15, 15, 15, 15, 63, 0, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b1111);
        check_output("sat edge1", 60, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b1111);
        check_output("sat edge2", 0, 1'b1, 1'b0);

        // refractory: w0=1, thr=1, ref=2 -> spikes at edges 1,4,7
        do_reset();
        load_config(1, 0, 0, 0, 1, 0, 2);
        for (int k = 1; k <= 7; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
            check_output($sformatf("refr edge%0d", k), 0, (k % 3) == 1, (k % 3) != 0);
        end

        // decay via constant-1 strobe: settles at 7, never fires
        do_reset();
        load_config(4, 0, 0, 0, 63, 1, 0);
        for (int k = 1; k <= 8; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
            check_output($sformatf("decay edge%0d", k), (k == 1) ? 4 : (k == 2) ? 6 : 7, 1'b0, 1'b0);
        end

        // no decay via constant-0 strobe: fires on edge 16
        do_reset();
        load_config(4, 0, 0, 0, 63, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
            check_output($sformatf("nodecay edge%0d", k), (k == 16) ? 0 : 4*k, k == 16, 1'b0);
        end

        // reset_nn during refractory clears the counter
        do_reset();
        load_config(1, 0, 0, 0, 1, 0, 3);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
        check_output("rnn fire", 0, 1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'b0001);
        check_output("rnn mid-refr", 1, 1'b0, 1'b0);

        // async reset mid-refractory, between clock edges
        do_reset();
        load_config(1, 0, 0, 0, 1, 0, 3);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
        check_output("async pre", 0, 1'b0, 1'b1);
        check_val("async pre bs_out", 32'(bs_out), 1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_output("async reset", 0, 1'b0, 1'b0);
        check_val("async reset bs_out", 32'(bs_out), 0);
        @(negedge clk);
        reset = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        check_output("async thr0 fires", 0, 1'b1, 1'b0);

`ifdef RETOSPECT_INHIB_EN
        // inhibitory weight: w0=-2, w1=5, clamped at zero
        do_reset();
        load_config(-2, 5, 0, 0, 63, 0, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0011);
        check_output("inhib 3", 3, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0011);
        check_output("inhib 6", 6, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
        check_output("inhib 4", 4, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
        check_output("inhib 2", 2, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
        check_output("inhib 0a", 0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'b0001);
        check_output("inhib 0b", 0, 1'b0, 1'b0);
`endif

        // random traffic against the model
        do_reset();
        for (int j = 0; j < L; j++) apply_stimulus(1'b0, 1'b1, 1'($urandom), 4'($urandom));
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 99);
            if (r < 3)       apply_stimulus(1'b1, 1'($urandom), 1'($urandom), 4'($urandom));
            else if (r < 8)  apply_stimulus(1'b0, 1'b1, 1'($urandom), 4'($urandom));
            else             apply_stimulus(1'b0, 1'b0, 1'b0, 4'($urandom));
            check_model($sformatf("random[%0d]", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
